midi_uart_tx: RTL and testbench

- Consumes the 8-bit note/program messages produced by the keyboard message encoder (`data`/`mstart`, back-pressured by `mready`).
- Expands each message into a standard MIDI channel message: note-on, note-off or program change.
- Serialises the result as 8N1 UART at MIDI baud on `tx`.
- Sits between the encoder and the MIDI output pin; holds a small message FIFO so no encoder message is lost while a multi-byte MIDI frame is being shifted out.

---
 rtl/midi_pkg.sv | 19 +
 rtl/uart_tx_byte.sv | 83 ++++++++
 rtl/midi_uart_tx.sv | 134 +++++++++++++
 tb/tb_midi_uart_tx.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// Shared status bytes, state encodings and baud-divisor helper for the MIDI UART transmitter.
package midi_pkg;

  localparam logic [7:0] NOTE_OFF = 8'h80;
  localparam logic [7:0] NOTE_ON  = 8'h90;
  localparam logic [7:0] PROG_CHG = 8'hC0;

  // Frame sequencer: pop a message, expand it, hand its bytes to the serialiser.
  typedef enum logic [1:0] {SEQ_IDLE, SEQ_LOAD, SEQ_SEND} seq_state_t;

  // Bit-level serialiser.
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser; a byte offered with start during the final stop-bit cycle follows
// with no idle gap. done is high during that final stop-bit cycle.
module uart_tx_byte
  import midi_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 3200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       start,
  output logic       tx,
  output logic       done
);

  localparam int unsigned    CW       = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0]  LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  PRE_LAST = CW'(CLKS_PER_BIT - 2);

  tx_state_t    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]   r_bit;
  logic [7:0]   r_shift;
  logic         w_tick;

  assign w_tick = (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= TX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      tx      <= 1'b1;
      done    <= 1'b0;
    end else begin
      done  <= (r_state == TX_STOP) && (r_cnt == PRE_LAST);
      r_cnt <= ((r_state == TX_IDLE) || w_tick) ? '0 : r_cnt + CW'(1);
      unique case (r_state)
        TX_IDLE: begin
          if (start) begin
            r_shift <= byte_in;
            tx      <= 1'b0;
            r_state <= TX_START;
          end
        end
        TX_START: begin
          if (w_tick) begin
            tx      <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_bit   <= '0;
            r_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (w_tick) begin
            if (r_bit == 3'd7) begin
              tx      <= 1'b1;
              r_state <= TX_STOP;
            end else begin
              tx      <= r_shift[0];
              r_shift <= r_shift >> 1;
              r_bit   <= r_bit + 3'd1;
            end
          end
        end
        TX_STOP: begin
          if (w_tick) begin
            if (start) begin
              r_shift <= byte_in;
              tx      <= 1'b0;
              r_state <= TX_START;
            end else begin
              r_state <= TX_IDLE;
            end
          end
        end
        default: r_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/midi_uart_tx.sv
// Buffers encoder messages, expands each into a MIDI channel message and
// shifts it out as 8N1 UART at MIDI baud.
module midi_uart_tx
  import midi_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100000000,
  parameter int unsigned BAUD      = 31250,
  parameter int unsigned CHANNEL   = 0,
  parameter int unsigned NOTE_BASE = 48,
  parameter int unsigned VELOCITY  = 100,
  parameter int unsigned DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       mstart,
  output logic       mready,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned      CPB     = clks_per_bit(CLK_HZ, BAUD);
  localparam int unsigned      AW      = $clog2(DEPTH);
  localparam int unsigned      CNTW    = AW + 1;
  localparam logic [CNTW-1:0]  RDY_MAX = CNTW'(DEPTH - 2);
  localparam logic [7:0]       CH      = {4'h0, 4'(CHANNEL)};

  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wr;
  logic [AW-1:0]   r_rd;
  logic [CNTW-1:0] r_count;
  logic            r_mready_q;
  seq_state_t      r_seq;
  logic [7:0]      r_msg;
  logic [23:0]     r_buf;
  logic [1:0]      r_left;
  logic            r_go;

  logic            w_push;
  logic            w_pop;
  logic            w_done;
  logic            w_start;
  logic            w_frame_end;
  logic [CNTW-1:0] w_count_next;
  logic [7:0]      w_key;
  logic [23:0]     w_frame;
  logic [1:0]      w_len;

  // Capture is qualified by last cycle's mready: the encoder reacts one edge late.
  always_comb begin
    w_push       = mstart && (data != 8'h00) && r_mready_q;
    w_pop        = (r_seq == SEQ_IDLE) && (r_count != '0);
    w_count_next = r_count + CNTW'(w_push) - CNTW'(w_pop);
    w_start      = r_go || (w_done && (r_left != 2'd1));
    w_frame_end  = (r_seq == SEQ_SEND) && w_done && (r_left == 2'd1);
  end

  // Expand the popped message; byte 0 (status) sits in the low lane.
  always_comb begin
    w_key = {1'b0, {1'b0, r_msg[7:2]} + 7'(NOTE_BASE)};
    if (r_msg[0]) begin
      w_frame = {8'h00, {1'b0, r_msg[7:1]}, PROG_CHG | CH};
      w_len   = 2'd2;
    end else if (r_msg[1]) begin
      w_frame = {8'(VELOCITY), w_key, NOTE_ON | CH};
      w_len   = 2'd3;
    end else begin
      w_frame = {8'h00, w_key, NOTE_OFF | CH};
      w_len   = 2'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seq      <= SEQ_IDLE;
      r_msg      <= '0;
      r_buf      <= '0;
      r_left     <= '0;
      r_go       <= 1'b0;
      r_wr       <= '0;
      r_rd       <= '0;
      r_count    <= '0;
      r_mready_q <= 1'b0;
      mready     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      r_mready_q <= mready;
      mready     <= (w_count_next <= RDY_MAX);
      busy       <= (w_count_next != '0) || w_pop || (r_seq == SEQ_LOAD) ||
                    ((r_seq == SEQ_SEND) && !w_frame_end);
      r_count    <= w_count_next;
      if (w_push)  r_wr  <= r_wr + AW'(1);
      if (w_pop)   r_rd  <= r_rd + AW'(1);
      // Each byte handed to the serialiser exposes the next one in the low lane.
      if (w_start) r_buf <= {8'h00, r_buf[23:8]};
      unique case (r_seq)
        SEQ_IDLE: begin
          if (w_pop) begin
            r_msg <= r_mem[r_rd];
            r_seq <= SEQ_LOAD;
          end
        end
        SEQ_LOAD: begin
          r_buf  <= w_frame;
          r_left <= w_len;
          r_go   <= 1'b1;
          r_seq  <= SEQ_SEND;
        end
        SEQ_SEND: begin
          r_go <= 1'b0;
          if (w_done) begin
            r_left <= r_left - 2'd1;
            if (r_left == 2'd1) r_seq <= SEQ_IDLE;
          end
        end
        default: r_seq <= SEQ_IDLE;
      endcase
    end
  end

  uart_tx_byte #(.CLKS_PER_BIT(CPB)) u_tx (
    .clk    (clk),
    .rst    (rst),
    .byte_in(r_buf[7:0]),
    .start  (w_start),
    .tx     (tx),
    .done   (w_done)
  );

endmodule

// File: tb/tb_midi_uart_tx.sv
// Scoreboard bench for midi_uart_tx: expected MIDI bytes are queued as messages are
// driven and checked by a UART receiver model on tx.
module tb_midi_uart_tx;

  localparam int CPB       = 4;
  localparam int CH        = 0;
  localparam int NOTE_BASE = 48;
  localparam int VELOCITY  = 100;
  localparam int DEPTH     = 4;

  logic       clk;
  logic       rst;
  logic [7:0] data;
  logic       mstart;
  logic       mready;
  logic       tx;
  logic       busy;

  logic       tb_mready_q = 1'b0;
  logic [7:0] exp_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         rx_phase = -1;
  int         rx_count = 0;
  logic [7:0] rx_byte  = '0;
  logic       burst_active = 1'b0;
  logic       saw_mready_low = 1'b0;

  midi_uart_tx #(
    .CLK_HZ   (125000),
    .BAUD     (31250),
    .CHANNEL  (CH),
    .NOTE_BASE(NOTE_BASE),
    .VELOCITY (VELOCITY),
    .DEPTH    (DEPTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .data  (data),
    .mstart(mstart),
    .mready(mready),
    .tx    (tx),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) tb_mready_q <= mready;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_expected(input logic [7:0] d);
    logic [7:0] key;
    key = 8'(((int'(d) >> 2) + NOTE_BASE) % 128);
    if (d[0]) begin
      exp_q.push_back(8'(32'hC0 | CH));
      exp_q.push_back({1'b0, d[7:1]});
    end else if (d[1]) begin
      exp_q.push_back(8'(32'h90 | CH));
      exp_q.push_back(key);
      exp_q.push_back(8'(VELOCITY));
    end else begin
      exp_q.push_back(8'(32'h80 | CH));
      exp_q.push_back(key);
      exp_q.push_back(8'h00);
    end
  endtask

  // Called #1 after an edge; returns #1 after the capture edge.
  task automatic send_msg(input logic [7:0] d);
    int t = 0;
    while (!tb_mready_q && t < 400) begin
      @(posedge clk); #1; t++;
    end
    check_eq("send_ready", 32'(tb_mready_q), 1);
    if (tb_mready_q) begin
      data = d; mstart = 1'b1;
      push_expected(d);
      @(posedge clk); #1;
      data = 8'h00; mstart = 1'b0;
    end
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d);
    int w = 0;
    int n = 0;
    int exp_len;
    exp_len = d[0] ? 20 * CPB : 30 * CPB;
    send_msg(d);
    check_eq({tag, "_busy"}, 32'(busy), 1);
    while (tx && w < 20) begin @(posedge clk); #1; w++; end
    check_eq({tag, "_latency"}, w, 3);
    while (busy && n < 1000) begin @(posedge clk); #1; n++; end
    check_eq({tag, "_len"}, n, exp_len);
    check_eq({tag, "_drained"}, 32'(exp_q.size()), 0);
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < limit) begin @(posedge clk); #1; t++; end
    check_eq({tag, "_idle"}, 32'(exp_q.size() == 0 && !busy), 1);
  endtask

  // UART receiver: samples mid-bit on the falling clock edge.
  always @(negedge clk) begin
    if (rst) begin
      rx_phase = -1;
    end else if (rx_phase < 0) begin
      if (tx == 1'b0) rx_phase = 0;
    end else begin
      rx_phase++;
      if (rx_phase == CPB / 2) begin
        check_eq("rx_start", 32'(tx), 0);
      end else if (rx_phase == 9 * CPB + CPB / 2) begin
        check_eq("rx_stop", 32'(tx), 1);
        check_eq("rx_pending", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check_eq("rx_byte", rx_byte, exp_q.pop_front());
        rx_count++;
        rx_phase = -1;
      end else if (rx_phase % CPB == CPB / 2) begin
        rx_byte[rx_phase / CPB - 1] = tx;
      end
    end
  end

  // A capture must never land on a full FIFO unless the same edge pops.
  always @(negedge clk) begin
    if (!rst && mstart && data != 8'h00 && tb_mready_q)
      check_eq("fifo_full_capture", 32'(dut.r_count == DEPTH && !dut.w_pop), 0);
    if (burst_active && !mready) saw_mready_low = 1'b1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rx_before;
    int w;
    logic seen_low;
    logic seen_busy;
    logic [7:0] burst [6] = '{8'h01, 8'hFE, 8'hF8, 8'hFF, 8'h22, 8'h1C};

    rst = 1'b1; data = 8'h00; mstart = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_mready", 32'(mready), 0);
    check_eq("rst_tx", 32'(tx), 1);
    check_eq("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("mready_rise", 32'(mready), 1);

    run_frame("t1_note_off", 8'h1C);
    run_frame("t2_note_on", 8'h22);
    run_frame("t3_prog", 8'h0B);

    // Null bytes are ignored even with mstart held.
    rx_before = rx_count;
    seen_low = 1'b0; seen_busy = 1'b0;
    data = 8'h00; mstart = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (!tx) seen_low = 1'b1;
      if (busy) seen_busy = 1'b1;
    end
    mstart = 1'b0;
    check_eq("t4_null_tx", 32'(seen_low), 0);
    check_eq("t4_null_busy", 32'(seen_busy), 0);
    check_eq("t4_null_rx", rx_count - rx_before, 0);

    // Burst of six back-to-back messages through a four-deep FIFO.
    rx_before = rx_count;
    burst_active = 1'b1;
    foreach (burst[i]) send_msg(burst[i]);
    burst_active = 1'b0;
    check_eq("t5_mready_drop", 32'(saw_mready_low), 1);
    wait_idle("t5", 2000);
    check_eq("t5_rx_count", rx_count - rx_before, 16);

    // Reset in the middle of data bit 3 of the key byte (key 0x31, bit 3 = 0).
    send_msg(8'h06);
    send_msg(8'h0B);
    w = 0;
    while (tx && w < 20) begin @(posedge clk); #1; w++; end
    check_eq("t6_latency", w, 2);
    repeat (57) @(posedge clk);
    #1;
    check_eq("t6_bit3", 32'(tx), 0);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    check_eq("t6_rst_tx", 32'(tx), 1);
    check_eq("t6_rst_busy", 32'(busy), 0);
    check_eq("t6_rst_mready", 32'(mready), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("t6_mready_rise", 32'(mready), 1);
    rx_before = rx_count;
    seen_low = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (!tx || busy) seen_low = 1'b1;
    end
    check_eq("t6_flushed", 32'(seen_low), 0);
    check_eq("t6_no_rx", rx_count - rx_before, 0);
    run_frame("t6_after", 8'h0B);

    check_eq("final_queue", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
